// File: rtl/vlc_pkg.sv
// Shared types and constants for the lamp-sequence monitor.
//   mode_e   : decoded lighting mode presented on the mode output
//   step_e   : classification of one frame-to-frame step (mode_e plus ILLEGAL)
//   LAMP_*   : legal 3-lamp patterns, bit 0 innermost
//   LOCK_RUN_DEFAULT : consecutive same-type steps needed to lock
package vlc_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_LEFT   = 2'd1,
    MODE_RIGHT  = 2'd2,
    MODE_HAZARD = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    STEP_IDLE    = 3'd0,
    STEP_LEFT    = 3'd1,
    STEP_RIGHT   = 3'd2,
    STEP_HAZARD  = 3'd3,
    STEP_ILLEGAL = 3'd4
  } step_e;

  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_ONE = 3'b001;
  localparam logic [2:0] LAMP_TWO = 3'b011;
  localparam logic [2:0] LAMP_ALL = 3'b111;

  localparam int unsigned LOCK_RUN_DEFAULT = 4;

  // True for the four patterns that belong to the sweep sequence.
  function automatic logic lamp_valid(input logic [2:0] f);
    return (f == LAMP_OFF) || (f == LAMP_ONE) || (f == LAMP_TWO) || (f == LAMP_ALL);
  endfunction

  // Successor in the sweep 000->001->011->111->000; only meaningful for valid frames.
  function automatic logic [2:0] lamp_next(input logic [2:0] f);
    logic [2:0] n;
    case (f)
      LAMP_OFF: n = LAMP_ONE;
      LAMP_ONE: n = LAMP_TWO;
      LAMP_TWO: n = LAMP_ALL;
      default:  n = LAMP_OFF;
    endcase
    return n;
  endfunction

  function automatic mode_e step_to_mode(input step_e s);
    mode_e m;
    case (s)
      STEP_LEFT:   m = MODE_LEFT;
      STEP_RIGHT:  m = MODE_RIGHT;
      STEP_HAZARD: m = MODE_HAZARD;
      default:     m = MODE_IDLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/vlc_lamp_monitor_if.sv
// Step-classification bus: the previous and current lamp frames go to the
// classifier and the step type comes back.
//   master : frame-register side (drives frames, reads step)
//   slave  : classifier side (reads frames, drives step)
interface vlc_lamp_monitor_if import vlc_pkg::*; ();

  logic [2:0] prev_l;
  logic [2:0] prev_r;
  logic [2:0] cur_l;
  logic [2:0] cur_r;
  step_e      step;

  modport master (output prev_l, prev_r, cur_l, cur_r, input step);
  modport slave  (input prev_l, prev_r, cur_l, cur_r, output step);

endinterface

// File: rtl/vlc_step_classifier.sv
// Purely combinational classification of one lamp step (prev -> cur frames).
//   bus.prev_l/prev_r : frames held from the previous sample
//   bus.cur_l/cur_r   : frames observed this sample
//   bus.step          : IDLE, LEFT, RIGHT, HAZARD or ILLEGAL
module vlc_step_classifier import vlc_pkg::*; (
  vlc_lamp_monitor_if.slave bus
);

  logic idle_ok;
  logic left_ok;
  logic right_ok;
  logic hazard_ok;

  always_comb begin
    idle_ok = (bus.prev_l == LAMP_OFF) && (bus.prev_r == LAMP_OFF) &&
              (bus.cur_l  == LAMP_OFF) && (bus.cur_r  == LAMP_OFF);

    left_ok = (bus.prev_r == LAMP_OFF) && (bus.cur_r == LAMP_OFF) &&
              lamp_valid(bus.prev_l) && (bus.cur_l == lamp_next(bus.prev_l));

    right_ok = (bus.prev_l == LAMP_OFF) && (bus.cur_l == LAMP_OFF) &&
               lamp_valid(bus.prev_r) && (bus.cur_r == lamp_next(bus.prev_r));

    hazard_ok = (bus.prev_l == bus.prev_r) && (bus.cur_l == bus.cur_r) &&
                (((bus.prev_l == LAMP_OFF) && (bus.cur_l == LAMP_ALL)) ||
                 ((bus.prev_l == LAMP_ALL) && (bus.cur_l == LAMP_OFF)));

    // The four legal cases are mutually exclusive, so the order only sets the fallback.
    bus.step = STEP_ILLEGAL;
    if (idle_ok)        bus.step = STEP_IDLE;
    else if (left_ok)   bus.step = STEP_LEFT;
    else if (right_ok)  bus.step = STEP_RIGHT;
    else if (hazard_ok) bus.step = STEP_HAZARD;
  end

endmodule

// File: rtl/vlc_lamp_monitor.sv
// Turn-signal / hazard lamp sequence monitor.
//   clk, rst_n            : clock and synchronous active-low reset
//   sample_en             : a lamp frame is valid this cycle
//   left_lamp, right_lamp : observed frames, bit 0 innermost
//   mode                  : decoded mode (0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD)
//   locked                : mode confirmed by LOCK_RUN consecutive same-type steps
//   fault                 : one-cycle pulse after an illegal step
//   fault_cnt             : saturating count of illegal steps
module vlc_lamp_monitor import vlc_pkg::*; #(
  parameter int unsigned LOCK_RUN = LOCK_RUN_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_en,
  input  logic [2:0] left_lamp,
  input  logic [2:0] right_lamp,
  output logic [1:0] mode,
  output logic       locked,
  output logic       fault,
  output logic [7:0] fault_cnt
);

  localparam logic [2:0] LOCK_RUN_W = 3'(LOCK_RUN);

  logic [2:0] prev_l_q, prev_l_d;
  logic [2:0] prev_r_q, prev_r_d;
  step_e      cand_q, cand_d;
  logic [2:0] run_cnt_q, run_cnt_d;
  mode_e      mode_q, mode_d;
  logic       locked_q, locked_d;
  logic       fault_q, fault_d;
  logic [7:0] fault_cnt_q, fault_cnt_d;
  step_e      step;

  vlc_lamp_monitor_if step_bus ();

  assign step_bus.prev_l = prev_l_q;
  assign step_bus.prev_r = prev_r_q;
  assign step_bus.cur_l  = left_lamp;
  assign step_bus.cur_r  = right_lamp;
  assign step            = step_bus.step;

  vlc_step_classifier u_classifier (
    .bus (step_bus)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_l_q    <= LAMP_OFF;
      prev_r_q    <= LAMP_OFF;
      cand_q      <= STEP_IDLE;
      run_cnt_q   <= '0;
      mode_q      <= MODE_IDLE;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
      fault_cnt_q <= '0;
    end else begin
      prev_l_q    <= prev_l_d;
      prev_r_q    <= prev_r_d;
      cand_q      <= cand_d;
      run_cnt_q   <= run_cnt_d;
      mode_q      <= mode_d;
      locked_q    <= locked_d;
      fault_q     <= fault_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  always_comb begin
    prev_l_d    = prev_l_q;
    prev_r_d    = prev_r_q;
    cand_d      = cand_q;
    run_cnt_d   = run_cnt_q;
    mode_d      = mode_q;
    locked_d    = locked_q;
    fault_d     = 1'b0;
    fault_cnt_d = fault_cnt_q;

    if (sample_en) begin
      prev_l_d = left_lamp;
      prev_r_d = right_lamp;
      if (step == STEP_ILLEGAL) begin
        fault_d   = 1'b1;
        if (fault_cnt_q != '1) fault_cnt_d = fault_cnt_q + 8'd1;
        cand_d    = STEP_IDLE;
        run_cnt_d = '0;
        locked_d  = 1'b0;
        mode_d    = MODE_IDLE;
      end else if (step == cand_q) begin
        if (run_cnt_q < LOCK_RUN_W) run_cnt_d = run_cnt_q + 3'd1;
        // Compare against LOCK_RUN-1 so a run saturated at 7 cannot wrap the test.
        if (run_cnt_q >= LOCK_RUN_W - 3'd1) begin
          locked_d = 1'b1;
          mode_d   = step_to_mode(cand_q);
        end
      end else begin
        // A new step type restarts the run; mode keeps its last confirmed value.
        cand_d    = step;
        run_cnt_d = 3'd1;
        locked_d  = 1'b0;
      end
    end
  end

  assign mode      = mode_q;
  assign locked    = locked_q;
  assign fault     = fault_q;
  assign fault_cnt = fault_cnt_q;

endmodule

// File: tb/tb_vlc_lamp_monitor.sv
// Scoreboard bench for vlc_lamp_monitor: stimulus pushes hand-computed
// expectations, a monitor pops and compares after every sampled or reset edge
// and checks that idle cycles hold all outputs with fault low.
module tb_vlc_lamp_monitor;
  import vlc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_en = 1'b0;
  logic [2:0] left_lamp = 3'b000;
  logic [2:0] right_lamp = 3'b000;
  logic [1:0] mode;
  logic       locked;
  logic       fault;
  logic [7:0] fault_cnt;

  int checks = 0;
  int failures = 0;
  int scen = 0;
  int idx = 0;

  typedef struct {
    logic [1:0] mode;
    logic       locked;
    logic       fault;
    logic [7:0] cnt;
    int         scen;
    int         idx;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur_e;
  exp_t last_e;
  bit   have_last = 1'b0;
  bit   sampled;

  always #5 clk = ~clk;

  vlc_lamp_monitor #(.LOCK_RUN(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_en  (sample_en),
    .left_lamp  (left_lamp),
    .right_lamp (right_lamp),
    .mode       (mode),
    .locked     (locked),
    .fault      (fault),
    .fault_cnt  (fault_cnt)
  );

  // Stand-alone classifier on its own bus for direct step-type checks.
  vlc_lamp_monitor_if cls_bus ();
  vlc_step_classifier u_cls (.bus(cls_bus));

  task automatic push_exp(input logic [1:0] m, input logic lk, input logic f, input logic [7:0] c);
    exp_t e;
    e.mode = m; e.locked = lk; e.fault = f; e.cnt = c; e.scen = scen; e.idx = idx;
    idx++;
    sb_q.push_back(e);
  endtask

  task automatic step(input logic [2:0] l, input logic [2:0] r,
                      input logic [1:0] m, input logic lk, input logic f, input logic [7:0] c);
    left_lamp = l; right_lamp = r; sample_en = 1'b1;
    push_exp(m, lk, f, c);
    @(negedge clk);
  endtask

  task automatic gap(input int n);
    sample_en = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset(input logic se, input logic [2:0] l, input logic [2:0] r);
    rst_n = 1'b0; sample_en = se; left_lamp = l; right_lamp = r;
    push_exp(2'd0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1; sample_en = 1'b0;
  endtask

  // Monitor: every edge with sample_en or reset active produces one expected response.
  always @(posedge clk) begin
    sampled = (sample_en === 1'b1) || (rst_n === 1'b0);
    #1;
    if (sampled) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow got mode=%0d locked=%0b fault=%0b cnt=%0d want a queued expectation",
                 mode, locked, fault, fault_cnt);
      end else begin
        cur_e = sb_q.pop_front();
        if (mode !== cur_e.mode || locked !== cur_e.locked || fault !== cur_e.fault || fault_cnt !== cur_e.cnt) begin
          failures++;
          $display("FAIL sample scen=%0d idx=%0d got mode=%0d locked=%0b fault=%0b cnt=%0d want mode=%0d locked=%0b fault=%0b cnt=%0d",
                   cur_e.scen, cur_e.idx, mode, locked, fault, fault_cnt,
                   cur_e.mode, cur_e.locked, cur_e.fault, cur_e.cnt);
        end
        last_e = cur_e;
        last_e.fault = 1'b0;
        have_last = 1'b1;
      end
    end else if (have_last) begin
      checks++;
      if (mode !== last_e.mode || locked !== last_e.locked || fault !== 1'b0 || fault_cnt !== last_e.cnt) begin
        failures++;
        $display("FAIL idle_hold scen=%0d got mode=%0d locked=%0b fault=%0b cnt=%0d want mode=%0d locked=%0b fault=0 cnt=%0d",
                 last_e.scen, mode, locked, fault, fault_cnt, last_e.mode, last_e.locked, last_e.cnt);
      end
    end
  end

  task automatic cls_check(input logic [2:0] pl, input logic [2:0] pr,
                           input logic [2:0] cl, input logic [2:0] cr, input step_e want);
    cls_bus.prev_l = pl; cls_bus.prev_r = pr; cls_bus.cur_l = cl; cls_bus.cur_r = cr;
    #1;
    checks++;
    if (cls_bus.step !== want) begin
      failures++;
      $display("FAIL classify %b/%b->%b/%b got step=%0d want step=%0d", pl, pr, cl, cr, cls_bus.step, want);
    end
  endtask

  initial begin
    cls_check(3'b000, 3'b000, 3'b000, 3'b000, STEP_IDLE);
    cls_check(3'b000, 3'b000, 3'b001, 3'b000, STEP_LEFT);
    cls_check(3'b011, 3'b000, 3'b111, 3'b000, STEP_LEFT);
    cls_check(3'b111, 3'b000, 3'b000, 3'b000, STEP_LEFT);
    cls_check(3'b000, 3'b000, 3'b000, 3'b001, STEP_RIGHT);
    cls_check(3'b000, 3'b111, 3'b000, 3'b000, STEP_RIGHT);
    cls_check(3'b111, 3'b111, 3'b000, 3'b000, STEP_HAZARD);
    cls_check(3'b000, 3'b000, 3'b111, 3'b111, STEP_HAZARD);
    cls_check(3'b000, 3'b000, 3'b011, 3'b000, STEP_ILLEGAL);
    cls_check(3'b001, 3'b001, 3'b011, 3'b011, STEP_ILLEGAL);
    cls_check(3'b101, 3'b000, 3'b011, 3'b000, STEP_ILLEGAL);
  end

  initial begin
    // Left sweep locks on the 4th step, stays locked, then a hazard step unlocks with mode held.
    scen = 1; do_reset(1'b0, 3'b000, 3'b000);
    step(3'b001, 3'b000, 2'd0, 1'b0, 1'b0, 8'd0);
    step(3'b011, 3'b000, 2'd0, 1'b0, 1'b0, 8'd0);
    step(3'b111, 3'b000, 2'd0, 1'b0, 1'b0, 8'd0);
    step(3'b000, 3'b000, 2'd1, 1'b1, 1'b0, 8'd0);
    step(3'b001, 3'b000, 2'd1, 1'b1, 1'b0, 8'd0);
    step(3'b011, 3'b000, 2'd1, 1'b1, 1'b0, 8'd0);
    step(3'b111, 3'b000, 2'd1, 1'b1, 1'b0, 8'd0);
    step(3'b000, 3'b000, 2'd1, 1'b1, 1'b0, 8'd0);
    step(3'b111, 3'b111, 2'd1, 1'b0, 1'b0, 8'd0);
    gap(2);

    // Hazard locks, then an illegal step out of 111/111 faults and clears.
    scen = 2; do_reset(1'b0, 3'b000, 3'b000);
    step(3'b111, 3'b111, 2'd0, 1'b0, 1'b0, 8'd0);
    step(3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 8'd0);
    step(3'b111, 3'b111, 2'd0, 1'b0, 1'b0, 8'd0);
    step(3'b000, 3'b000, 2'd3, 1'b1, 1'b0, 8'd0);
    step(3'b111, 3'b111, 2'd3, 1'b1, 1'b0, 8'd0);
    step(3'b001, 3'b000, 2'd0, 1'b0, 1'b1, 8'd1);
    gap(2);

    // Idle locks with mode 0; right sweep unlocks, then locks mode 2.
    scen = 3; do_reset(1'b0, 3'b000, 3'b000);
    step(3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 8'd0);
    step(3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 8'd0);
    step(3'b000, 3'b000, 2'd0, 1'b0, 1'b0, 8'd0);
    step(3'b000, 3'b000, 2'd0, 1'b1, 1'b0, 8'd0);
    step(3'b000, 3'b001, 2'd0, 1'b0, 1'b0, 8'd0);
    step(3'b000, 3'b011, 2'd0, 1'b0, 1'b0, 8'd0);
    step(3'b000, 3'b111, 2'd0, 1'b0, 1'b0, 8'd0);
    step(3'b000, 3'b000, 2'd2, 1'b1, 1'b0, 8'd0);
    gap(2);

    // Reset beats sample_en mid-sweep; the next frame is judged against 000/000.
    scen = 4; do_reset(1'b0, 3'b000, 3'b000);
    step(3'b001, 3'b000, 2'd0, 1'b0, 1'b0, 8'd0);
    step(3'b011, 3'b000, 2'd0, 1'b0, 1'b0, 8'd0);
    do_reset(1'b1, 3'b111, 3'b000);
    step(3'b011, 3'b000, 2'd0, 1'b0, 1'b1, 8'd1);
    gap(2);

    // 300 back-to-back illegal steps: fault every step, counter saturates at 255.
    scen = 5; do_reset(1'b0, 3'b000, 3'b000);
    for (int i = 0; i < 300; i++) begin
      step((i % 2 == 0) ? 3'b101 : 3'b010, 3'b000, 2'd0, 1'b0, 1'b1,
           (i + 1 > 255) ? 8'd255 : 8'(i + 1));
    end
    gap(2);

    // Left sweep with 0..3 idle cycles between frames.
    scen = 6; do_reset(1'b0, 3'b000, 3'b000);
    step(3'b001, 3'b000, 2'd0, 1'b0, 1'b0, 8'd0);
    gap(0);
    step(3'b011, 3'b000, 2'd0, 1'b0, 1'b0, 8'd0);
    gap(1);
    step(3'b111, 3'b000, 2'd0, 1'b0, 1'b0, 8'd0);
    gap(2);
    step(3'b000, 3'b000, 2'd1, 1'b1, 1'b0, 8'd0);
    gap(3);

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got pending=%0d want pending=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got time=%0t want completion before limit", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vlc_lamp_monitor.md
VLC_LAMP_MONITOR -- requirements
Module: vlc_lamp_monitor

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset; synchronous, active-low.
REQ-003 SHALL have port: sample_en  input  1  one lamp frame is valid this cycle; may be high on consecutive cycles.
REQ-004 SHALL have port: left_lamp  input  3  observed left lamp frame; bit 0 is innermost.
REQ-005 SHALL have port: right_lamp  input  3  observed right lamp frame; bit 0 is innermost.
REQ-006 SHALL have port: mode  output  2  decoded lighting mode: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD.
REQ-007 SHALL have port: locked  output  1  mode confirmed by a full run of legal steps.
REQ-008 SHALL have port: fault  output  1  one-cycle pulse on an illegal step.
REQ-009 SHALL have port: fault_cnt  output  8  count of illegal steps, saturating.
REQ-010 SHALL use parameter LOCK_RUN, default 4, consecutive same-type steps needed to lock (range 2..7).

Function
REQ-011 SHALL hold prev_l and prev_r registers, loaded from left_lamp and right_lamp on every sample_en cycle.
REQ-012 SHALL classify each sampled step (prev frame -> current frame) as IDLE, LEFT, RIGHT, HAZARD or ILLEGAL.
REQ-013 LEFT step SHALL require prev_r = cur_r = 000 and cur_l = next(prev_l), where next is 000->001->011->111->000.
REQ-014 RIGHT step SHALL mirror LEFT with the sides swapped.
REQ-015 HAZARD step SHALL require prev_l = prev_r, cur_l = cur_r, and 000->111 or 111->000.
REQ-016 IDLE step SHALL require all four frames = 000; every other combination SHALL be ILLEGAL.
REQ-017 SHALL keep cand (step type) and run_cnt (3 bits, saturating at LOCK_RUN).
REQ-018 A legal step equal to cand SHALL increment run_cnt. When run_cnt reaches LOCK_RUN, it SHALL set locked=1 and mode=cand.
REQ-019 A legal step differing from cand SHALL set cand to that step, set run_cnt=1 and clear locked. mode SHALL hold its last value.
REQ-020 An ILLEGAL step SHALL pulse fault for exactly one cycle, increment fault_cnt (saturating at 255), clear run_cnt, locked and cand (cand=IDLE), and force mode=IDLE.
REQ-021 All outputs SHALL be registered and SHALL update on the cycle after the sample_en cycle that caused the change.
REQ-022 Cycles with sample_en=0 SHALL leave all state unchanged, and fault SHALL be 0 on those cycles.
REQ-023 When locked, further matching steps SHALL keep locked=1 with no output change.

Reset
REQ-024 With rst_n=0 at a rising edge, the block SHALL set prev_l=prev_r=000, cand=IDLE, run_cnt=0, mode=0, locked=0, fault=0 and fault_cnt=0.
REQ-025 Reset SHALL take priority over sample_en in the same cycle. Reset mid-sequence SHALL discard the partial run.
REQ-026 The first sample after reset SHALL be classified against prev=000/000.

Structure
REQ-027 Shared package vlc_pkg SHALL hold the mode enum (IDLE/LEFT/RIGHT/HAZARD), the step-type enum (adds ILLEGAL), the lamp pattern constants 000/001/011/111, and the LOCK_RUN default.
REQ-028 Classification SHALL be a purely combinational sub-module, vlc_step_classifier (prev_l, prev_r, cur_l, cur_r -> step type).
REQ-029 vlc_lamp_monitor SHALL contain the frame registers, the run/lock logic and the fault counter.

Verification
REQ-030 After reset, feed left frames 001, 011, 111, 000 with R=000, one per sample_en -> locked=1, mode=1 one cycle after the 4th sample, fault=0 throughout.
REQ-031 Feed hazard 111/111, 000/000, 111/111, 000/000 -> mode=3, locked=1. Then feed 001/000 -> fault pulse, fault_cnt=1, mode=0, locked=0.
REQ-032 Feed idle 000/000 x4 -> mode=0, locked=1. Then feed a right sequence 001, 011 -> locked=0 after the first right step, mode holds 0, run_cnt=2.
REQ-033 Apply rst_n=0 with sample_en=1 on the 3rd step of a left sequence -> all outputs reset. The next sample 011/000 -> fault=1, because 000->011 is illegal.
REQ-034 Apply 300 illegal steps (alternate 101/000, 010/000) -> fault_cnt saturates at 255 and fault pulses on every step.
REQ-035 Apply the left sequence with sample_en gaps of 0-3 idle cycles between frames -> same lock result as REQ-030 and no spurious fault.
